fetch_stage: RTL



---
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : RV32I instruction-fetch stage with IF/ID pipeline register.
//                Issues one request at a time to a variable-latency
//                instruction memory, discards responses made stale by a
//                redirect, and buffers one instruction while decode stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        ImemAck,
    input  logic [31:0] ImemRData,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] hold_buf;

    logic [31:0] redirect_pc;
    logic [31:0] pc_plus4;
    logic        deliver_ok;
    logic        deliver;
    logic [31:0] deliver_data;

    // Redirect targets are always word aligned; the next sequential PC wraps.
    assign redirect_pc  = {PCTargetE[31:2], 2'b00};
    assign pc_plus4     = PCF + 32'd4;

    // An instruction may move into decode only when nothing holds or redirects.
    assign deliver_ok   = !StallF && !StallD && !PCSrcE;
    assign deliver      = deliver_ok && (((state == S_WAIT) && ImemAck) || (state == S_HOLD));
    assign deliver_data = (state == S_HOLD) ? hold_buf : ImemRData;

    assign ImemAddr     = PCF;

    // Fetch sequencer: PC update, request strobe and one-entry hold buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_BOOT;
            PCF      <= RESET_PC;
            ImemReq  <= 1'b0;
            hold_buf <= '0;
        end else begin
            ImemReq <= 1'b0;
            case (state)
                S_BOOT: begin
                    state   <= S_REQ;
                    ImemReq <= 1'b1;
                end
                S_REQ: begin
                    // The request issued this cycle becomes stale on a redirect.
                    if (PCSrcE) begin
                        PCF   <= redirect_pc;
                        state <= S_DROP;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ImemAck) begin
                        if (PCSrcE) begin
                            PCF     <= redirect_pc;
                            state   <= S_REQ;
                            ImemReq <= 1'b1;
                        end else if (deliver_ok) begin
                            PCF     <= pc_plus4;
                            state   <= S_REQ;
                            ImemReq <= 1'b1;
                        end else begin
                            hold_buf <= ImemRData;
                            state    <= S_HOLD;
                        end
                    end else if (PCSrcE) begin
                        PCF   <= redirect_pc;
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    // Follow any further redirect while draining the stale response.
                    if (PCSrcE) begin
                        PCF <= redirect_pc;
                    end
                    if (ImemAck) begin
                        state   <= S_REQ;
                        ImemReq <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (PCSrcE) begin
                        PCF     <= redirect_pc;
                        state   <= S_REQ;
                        ImemReq <= 1'b1;
                    end else if (deliver_ok) begin
                        PCF     <= pc_plus4;
                        state   <= S_REQ;
                        ImemReq <= 1'b1;
                    end
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

    // IF/ID register: flush beats stall beats delivery; otherwise insert a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (StallD) begin
            InstrD   <= InstrD;
            PCD      <= PCD;
            PCPlus4D <= PCPlus4D;
            ValidD   <= ValidD;
        end else if (deliver) begin
            InstrD   <= deliver_data;
            PCD      <= PCF;
            PCPlus4D <= pc_plus4;
            ValidD   <= 1'b1;
        end else begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end
    end

endmodule

`default_nettype wire
